// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and the data-length helper.
package midi_pkg;

    // Channel-voice status high nibbles
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CONTROL  = 4'hB;
    localparam logic [3:0] PROGRAM  = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    // System byte boundaries
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    // Number of data bytes following a channel-voice status of the given type
    function automatic logic [1:0] data_len(input logic [3:0] msg_type);
        if (msg_type == PROGRAM || msg_type == CHAN_AT)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser with running status, real-time/system
// filtering and an optional single-channel filter.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       msg_valid,
    output logic [3:0] msg_type,
    output logic [3:0] msg_channel,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2
);

    state_t     state_reg;
    logic       rs_valid_reg;
    logic [7:0] rs_status_reg;
    logic [6:0] data1_reg;

    // Byte classification and completion of a message on this byte
    logic       is_realtime;
    logic       is_chan_status;
    logic       is_data;
    logic       msg_complete;
    logic       msg_accept;
    logic [3:0] emit_type;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;

    // Decode the incoming byte and form the candidate output message
    always_comb begin
        is_realtime    = (byte_data >= RT_MIN);
        is_chan_status = byte_data[7] && (byte_data[7:4] != 4'hF);
        is_data        = !byte_data[7];

        // A data byte completes a message either as the second byte, or as
        // the only byte of a 1-data-byte type (from IDLE via running status
        // or from WAIT_D1). WAIT_D1/WAIT_D2 imply rs_valid_reg is set.
        msg_complete = 1'b0;
        if (byte_valid && is_data) begin
            if (state_reg == WAIT_D2)
                msg_complete = 1'b1;
            else if (state_reg != SYSEX && rs_valid_reg &&
                     data_len(rs_status_reg[7:4]) == 2'd1)
                msg_complete = 1'b1;
        end

        if (state_reg == WAIT_D2) begin
            emit_d1 = data1_reg;
            emit_d2 = byte_data[6:0];
        end else begin
            emit_d1 = byte_data[6:0];
            emit_d2 = 7'd0;
        end

        // Note-on with zero velocity is reported as note-off
        if (rs_status_reg[7:4] == NOTE_ON && emit_d2 == 7'd0)
            emit_type = NOTE_OFF;
        else
            emit_type = rs_status_reg[7:4];

        msg_accept = OMNI || (rs_status_reg[3:0] == CHANNEL);
    end

    // Parser FSM, running-status latch and registered message outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rs_valid_reg  <= 1'b0;
            rs_status_reg <= 8'd0;
            data1_reg     <= 7'd0;
            msg_valid     <= 1'b0;
            msg_type      <= 4'd0;
            msg_channel   <= 4'd0;
            msg_data1     <= 7'd0;
            msg_data2     <= 7'd0;
        end else begin
            msg_valid <= 1'b0;
            if (byte_valid && !is_realtime) begin
                if (is_chan_status) begin
                    // New status from any state (also closes an open SysEx)
                    rs_status_reg <= byte_data;
                    rs_valid_reg  <= 1'b1;
                    state_reg     <= WAIT_D1;
                end else if (state_reg == SYSEX) begin
                    if (byte_data == SYSEX_END)
                        state_reg <= IDLE;
                end else if (byte_data[7]) begin
                    // System common / SysEx start kill running status
                    rs_valid_reg <= 1'b0;
                    state_reg    <= (byte_data == SYSEX_START) ? SYSEX : IDLE;
                end else if (msg_complete) begin
                    state_reg <= IDLE;
                    if (msg_accept) begin
                        msg_valid   <= 1'b1;
                        msg_type    <= emit_type;
                        msg_channel <= rs_status_reg[3:0];
                        msg_data1   <= emit_d1;
                        msg_data2   <= emit_d2;
                    end
                end else if (rs_valid_reg) begin
                    // First of two data bytes (explicit or running status)
                    data1_reg <= byte_data[6:0];
                    state_reg <= WAIT_D2;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench: two parsers (omni and channel-2 only) share one byte
// stream; a behavioural model queues expected messages, monitors compare.
module tb_midi_msg_parser;

    typedef struct {
        logic [3:0] t;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;

    logic       mv_a, mv_b;
    logic [3:0] mt_a, mt_b, mc_a, mc_b;
    logic [6:0] d1_a, d1_b, d2_a, d2_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a, last_b;

    // Reference model state
    int  rs_status;
    int  pend[$];
    bit  in_sysex;

    midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .msg_valid(mv_a), .msg_type(mt_a), .msg_channel(mc_a),
        .msg_data1(d1_a), .msg_data2(d2_a)
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_b (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .msg_valid(mv_b), .msg_type(mt_b), .msg_channel(mc_b),
        .msg_data1(d1_b), .msg_data2(d2_b)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency checks
    always @(posedge clk) cycle_cnt++;

    function automatic exp_t zero_exp();
        exp_t e;
        e.t = 4'd0; e.ch = 4'd0; e.d1 = 7'd0; e.d2 = 7'd0; e.cyc = 0;
        return e;
    endfunction

    task automatic model_reset();
        rs_status = -1;
        pend.delete();
        in_sysex = 1'b0;
        last_a = zero_exp();
        last_b = zero_exp();
    endtask

    task automatic model_emit();
        exp_t e;
        int   need;
        e.t  = 4'(rs_status >> 4);
        e.ch = 4'(rs_status & 15);
        need = (e.t == 4'hC || e.t == 4'hD) ? 1 : 2;
        e.d1 = 7'(pend[0]);
        e.d2 = (need == 2) ? 7'(pend[1]) : 7'd0;
        if (e.t == 4'h9 && e.d2 == 7'd0) e.t = 4'h8;
        e.cyc = cycle_cnt + 1;
        q_a.push_back(e);
        if (e.ch == 4'd2) q_b.push_back(e);
    endtask

    task automatic model_status(input int b);
        rs_status = b;
        pend.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v;
        int need;
        v = int'(b);
        if (v >= 'hF8) return;
        if (in_sysex) begin
            if (v == 'hF7) in_sysex = 1'b0;
            else if (v >= 'h80 && v <= 'hEF) begin
                in_sysex = 1'b0;
                model_status(v);
            end
            return;
        end
        if (v >= 'h80 && v <= 'hEF) model_status(v);
        else if (v >= 'hF0) begin
            rs_status = -1;
            pend.delete();
            if (v == 'hF0) in_sysex = 1'b1;
        end else if (rs_status >= 0) begin
            pend.push_back(v);
            need = ((rs_status >> 4) == 'hC || (rs_status >> 4) == 'hD) ? 1 : 2;
            if (pend.size() == need) begin
                model_emit();
                pend.delete();
            end
        end
    endtask

    // Called at posedge+1; drives one byte for one cycle
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        model_byte(b);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            byte_data = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
        idle(3);
    endtask

    task automatic do_reset(input int n);
        idle(2);
        rst = 1'b1;
        model_reset();
        idle(n);
        rst = 1'b0;
    endtask

    // Monitor for the omni instance
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (mv_a) begin
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_spurious: got msg %h %h %h %h at cycle %0d, none expected",
                             mt_a, mc_a, d1_a, d2_a, cycle_cnt);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    if (mt_a !== e.t || mc_a !== e.ch || d1_a !== e.d1 || d2_a !== e.d2 ||
                        cycle_cnt != e.cyc) begin
                        n_fail++;
                        $display("FAIL a_msg: got %h %h %h %h cyc %0d, expected %h %h %h %h cyc %0d",
                                 mt_a, mc_a, d1_a, d2_a, cycle_cnt, e.t, e.ch, e.d1, e.d2, e.cyc);
                    end
                    last_a = e;
                end
            end else if (mt_a !== last_a.t || mc_a !== last_a.ch ||
                         d1_a !== last_a.d1 || d2_a !== last_a.d2) begin
                n_fail++;
                $display("FAIL a_hold: got %h %h %h %h, expected %h %h %h %h at cycle %0d",
                         mt_a, mc_a, d1_a, d2_a, last_a.t, last_a.ch, last_a.d1, last_a.d2, cycle_cnt);
            end
        end
    end

    // Monitor for the channel-2 instance
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (mv_b) begin
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_spurious: got msg %h %h %h %h at cycle %0d, none expected",
                             mt_b, mc_b, d1_b, d2_b, cycle_cnt);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    if (mt_b !== e.t || mc_b !== e.ch || d1_b !== e.d1 || d2_b !== e.d2 ||
                        cycle_cnt != e.cyc) begin
                        n_fail++;
                        $display("FAIL b_msg: got %h %h %h %h cyc %0d, expected %h %h %h %h cyc %0d",
                                 mt_b, mc_b, d1_b, d2_b, cycle_cnt, e.t, e.ch, e.d1, e.d2, e.cyc);
                    end
                    last_b = e;
                end
            end else if (mt_b !== last_b.t || mc_b !== last_b.ch ||
                         d1_b !== last_b.d1 || d2_b !== last_b.d2) begin
                n_fail++;
                $display("FAIL b_hold: got %h %h %h %h, expected %h %h %h %h at cycle %0d",
                         mt_b, mc_b, d1_b, d2_b, last_b.t, last_b.ch, last_b.d1, last_b.d2, cycle_cnt);
            end
        end
    end

    // Stimulus: directed sequences, then randomized traffic
    initial begin
        logic [7:0] b;
        int r;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        model_reset();
        @(posedge clk); #1;
        idle(3);
        rst = 1'b0;
        idle(3);

        send_seq('{8'h90, 8'h3C, 8'h64});
        send_seq('{8'h91, 8'h40, 8'h50, 8'h42, 8'h00});
        send_seq('{8'h93, 8'hF8, 8'h3C, 8'hFE, 8'h64});
        send_seq('{8'hC5, 8'h07, 8'h09});
        send_seq('{8'hF0, 8'h3C, 8'h7F, 8'h90, 8'hF7, 8'h3C, 8'h64});
        send_seq('{8'h90, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64});
        send_seq('{8'hB2, 8'h07, 8'h40, 8'h0A, 8'h20, 8'hD2, 8'h33, 8'hF3, 8'h11, 8'h22});
        send_seq('{8'hE2, 8'h00, 8'h40, 8'h92, 8'h3C});
        do_reset(2);
        send_seq('{8'h3C, 8'h64});

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
            else if (r < 80) b = 8'($urandom_range('h80, 'hEF));
            else if (r < 84) b = 8'hF0;
            else if (r < 88) b = 8'hF7;
            else if (r < 91) b = 8'($urandom_range('hF1, 'hF6));
            else             b = 8'($urandom_range('hF8, 'hFF));
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
        end

        idle(5);
        n_checks++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL a_drain: %0d messages still expected, required 0", q_a.size());
        end
        n_checks++;
        if (q_b.size() != 0) begin
            n_fail++;
            $display("FAIL b_drain: %0d messages still expected, required 0", q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
